// File: rtl/pulse_event_scheduler.sv
// -----------------------------------------------------------------------------
// pulse_event_scheduler
//
// Time-driven sequencer that steps through a programmable schedule table and
// feeds one-cycle event vectors to the downstream pulse generator. Each table
// entry holds an event mask and a duration in clock cycles. The mask of an
// entry is emitted for exactly one cycle when that entry activates, and the
// entry then occupies max(duration, 1) cycles before the next one activates.
// After the last active entry the table wraps to entry 0 until stopped.
//
// Ports:
//   clk              single clock, rising edge
//   rst              synchronous, active-high reset
//   cfg_we           table write strobe (one entry per cycle, allowed in RUN)
//   cfg_addr         table entry written
//   cfg_mask         event mask for the written entry
//   cfg_duration     duration of the written entry in cycles
//   cfg_num_entries  active entry count, latched when a run starts
//   start            one-cycle request to begin running
//   stop             one-cycle request to halt (wins over start)
//   event_out        one-cycle event vector to the pulse generator
//   busy             high while running
//   entry_idx        index of the current entry
//   cycle_done       high in the last cycle of the last active entry
//   start_err        one-cycle strobe when a start request is rejected
// -----------------------------------------------------------------------------
module pulse_event_scheduler #(
    parameter int NUM_EVENTS     = 64,
    parameter int NUM_ENTRIES    = 16,
    parameter int DURATION_WIDTH = 24,
    parameter int IDX_W          = $clog2(NUM_ENTRIES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [IDX_W-1:0]          cfg_addr,
    input  logic [NUM_EVENTS-1:0]     cfg_mask,
    input  logic [DURATION_WIDTH-1:0] cfg_duration,
    input  logic [IDX_W:0]            cfg_num_entries,
    input  logic                      start,
    input  logic                      stop,
    output logic [NUM_EVENTS-1:0]     event_out,
    output logic                      busy,
    output logic [IDX_W-1:0]          entry_idx,
    output logic                      cycle_done,
    output logic                      start_err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [DURATION_WIDTH-1:0] CNT_ZERO = {DURATION_WIDTH{1'b0}};
    localparam logic [DURATION_WIDTH-1:0] CNT_ONE  = {{(DURATION_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]          IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]          IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W:0]            NUM_ZERO = {(IDX_W+1){1'b0}};
    localparam logic [IDX_W:0]            NUM_ONE  = {{IDX_W{1'b0}}, 1'b1};
    localparam logic [IDX_W:0]            NUM_MAX  = (IDX_W+1)'(NUM_ENTRIES);
    localparam logic [NUM_EVENTS-1:0]     EVT_ZERO = {NUM_EVENTS{1'b0}};

    // A zero duration is treated as a one-cycle entry so the sequence never stalls.
    function automatic logic [DURATION_WIDTH-1:0] load_count(
        input logic [DURATION_WIDTH-1:0] dur
    );
        logic [DURATION_WIDTH-1:0] res;
        if (dur == CNT_ZERO) begin
            res = CNT_ONE;
        end else begin
            res = dur;
        end
        return res;
    endfunction

    // Schedule table (intentionally not reset; survives stop/start)
    logic [NUM_EVENTS-1:0]     mask_mem_r [NUM_ENTRIES];
    logic [DURATION_WIDTH-1:0] dur_mem_r  [NUM_ENTRIES];

    // Sequencer state
    logic [0:0]                state_r;
    logic [IDX_W-1:0]          idx_r;
    logic [IDX_W-1:0]          last_idx_r;   // latched n-1
    logic [DURATION_WIDTH-1:0] cnt_r;        // cycles left in current entry, including this one
    logic [NUM_EVENTS-1:0]     event_r;
    logic                      done_r;
    logic                      err_r;

    // Next-state values
    logic [0:0]                state_nxt_s;
    logic [IDX_W-1:0]          idx_nxt_s;
    logic [IDX_W-1:0]          last_idx_nxt_s;
    logic [DURATION_WIDTH-1:0] cnt_nxt_s;
    logic [NUM_EVENTS-1:0]     event_nxt_s;
    logic                      done_nxt_s;
    logic                      err_nxt_s;

    // Helper decodes
    logic                      num_valid_s;
    logic [IDX_W:0]            num_m1_s;
    logic                      expire_s;
    logic [IDX_W-1:0]          wrap_idx_s;

    // Table write port; a write to the entry activating this same edge is
    // naturally seen only on its next activation because the read below uses
    // the pre-edge contents.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            mask_mem_r[cfg_addr] <= cfg_mask;
            dur_mem_r[cfg_addr]  <= cfg_duration;
        end
    end

    // Decode start validity, counter expiry and the wrapped successor index.
    always_comb begin
        num_valid_s = (cfg_num_entries != NUM_ZERO) && (cfg_num_entries <= NUM_MAX);
        num_m1_s    = cfg_num_entries - NUM_ONE;
        expire_s    = (state_r == ST_RUN) && (cnt_r == CNT_ONE);
        if (idx_r == last_idx_r) begin
            wrap_idx_s = IDX_ZERO;
        end else begin
            wrap_idx_s = idx_r + IDX_ONE;
        end
    end

    // Next-state logic for the IDLE/RUN sequencer.
    always_comb begin
        state_nxt_s    = state_r;
        idx_nxt_s      = idx_r;
        last_idx_nxt_s = last_idx_r;
        cnt_nxt_s      = cnt_r;
        event_nxt_s    = EVT_ZERO;
        err_nxt_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (stop) begin
                    // stop wins over a simultaneous start
                    state_nxt_s = ST_IDLE;
                end else if (start) begin
                    if (num_valid_s) begin
                        state_nxt_s    = ST_RUN;
                        idx_nxt_s      = IDX_ZERO;
                        last_idx_nxt_s = num_m1_s[IDX_W-1:0];
                        cnt_nxt_s      = load_count(dur_mem_r[IDX_ZERO]);
                        event_nxt_s    = mask_mem_r[IDX_ZERO];
                    end else begin
                        err_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    // Abandon the in-progress entry; suppress any activation.
                    state_nxt_s = ST_IDLE;
                    idx_nxt_s   = IDX_ZERO;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (expire_s) begin
                    idx_nxt_s   = wrap_idx_s;
                    cnt_nxt_s   = load_count(dur_mem_r[wrap_idx_s]);
                    event_nxt_s = mask_mem_r[wrap_idx_s];
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = IDX_ZERO;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // cycle_done is registered, so it is decided from the values the state
    // will hold next cycle: last entry with one cycle remaining.
    always_comb begin
        if ((state_nxt_s == ST_RUN) && (cnt_nxt_s == CNT_ONE) &&
            (idx_nxt_s == last_idx_nxt_s)) begin
            done_nxt_s = 1'b1;
        end else begin
            done_nxt_s = 1'b0;
        end
    end

    // Sequencer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= IDX_ZERO;
            last_idx_r <= IDX_ZERO;
            cnt_r      <= CNT_ZERO;
            event_r    <= EVT_ZERO;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            idx_r      <= idx_nxt_s;
            last_idx_r <= last_idx_nxt_s;
            cnt_r      <= cnt_nxt_s;
            event_r    <= event_nxt_s;
            done_r     <= done_nxt_s;
            err_r      <= err_nxt_s;
        end
    end

    assign event_out  = event_r;
    assign busy       = (state_r == ST_RUN);
    assign entry_idx  = idx_r;
    assign cycle_done = done_r;
    assign start_err  = err_r;

endmodule

// File: tb/tb_pulse_event_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for pulse_event_scheduler. Directed scenarios plus a randomized
// run checked against a time-based reference model: each activation records
// the absolute cycle at which the following entry is due.
// -----------------------------------------------------------------------------
module tb_pulse_event_scheduler;
    localparam int NE = 64;
    localparam int NT = 16;
    localparam int DW = 24;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_addr = '0;
    logic [NE-1:0] cfg_mask = '0;
    logic [DW-1:0] cfg_duration = '0;
    logic [IW:0]   cfg_num_entries = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [NE-1:0] event_out;
    logic          busy;
    logic [IW-1:0] entry_idx;
    logic          cycle_done;
    logic          start_err;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic [NE-1:0] m_mask [NT];
    int            m_dur  [NT];
    bit            m_run = 1'b0;
    int            m_n = 1;
    int            m_cur = 0;
    longint        m_end = 0;
    longint        m_edge = 0;
    logic [NE-1:0] x_evt = '0;
    bit            x_done = 1'b0;
    bit            x_err = 1'b0;

    localparam logic [NE-1:0] M0 = 64'h0000_0000_0000_0001;
    localparam logic [NE-1:0] M1 = 64'h8000_0000_0000_0000;
    localparam logic [NE-1:0] M2 = 64'h0000_0001_0001_0000;

    pulse_event_scheduler #(
        .NUM_EVENTS(NE), .NUM_ENTRIES(NT), .DURATION_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_mask(cfg_mask), .cfg_duration(cfg_duration),
        .cfg_num_entries(cfg_num_entries), .start(start), .stop(stop),
        .event_out(event_out), .busy(busy), .entry_idx(entry_idx),
        .cycle_done(cycle_done), .start_err(start_err)
    );

    always #5 clk = ~clk;

    function automatic void model_activate();
        int len;
        len = (m_dur[m_cur] == 0) ? 1 : m_dur[m_cur];
        x_evt = m_mask[m_cur];
        m_end = m_edge + len;
    endfunction

    // Advance the model by one clock edge using the inputs presented at it.
    function automatic void model_edge();
        m_edge++;
        x_evt = '0;
        x_err = 1'b0;
        if (rst) begin
            m_run = 1'b0;
            m_cur = 0;
        end else if (m_run) begin
            if (stop) begin
                m_run = 1'b0;
                m_cur = 0;
            end else if (m_edge == m_end) begin
                m_cur = (m_cur + 1) % m_n;
                model_activate();
            end
        end else if (!stop && start) begin
            if (cfg_num_entries >= 1 && cfg_num_entries <= NT) begin
                m_run = 1'b1;
                m_n = int'(cfg_num_entries);
                m_cur = 0;
                model_activate();
            end else begin
                x_err = 1'b1;
            end
        end
        if (cfg_we) begin
            m_mask[cfg_addr] = cfg_mask;
            m_dur[cfg_addr] = int'(cfg_duration);
        end
        x_done = m_run && (m_cur == m_n - 1) && (m_end == m_edge + 1);
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic write_entry(input int a, input logic [NE-1:0] m, input int d);
        cfg_we = 1'b1;
        cfg_addr = a[IW-1:0];
        cfg_mask = m;
        cfg_duration = d[DW-1:0];
        step();
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input int n);
        cfg_num_entries = n[IW:0];
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        vectors++;
        if (event_out !== '0 || busy !== 1'b0 || entry_idx !== '0 ||
            cycle_done !== 1'b0 || start_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: evt=%h busy=%b idx=%0d done=%b err=%b required all 0",
                     event_out, busy, entry_idx, cycle_done, start_err);
        end
        for (int i = 0; i < NT; i++) write_entry(i, '0, 1);
    endtask

    task automatic test_single_entry();
        write_entry(0, M0, 16);
        do_start(1);
        for (int r = 0; r < 48; r++) begin
            vectors++;
            if (event_out !== ((r % 16 == 0) ? M0 : 64'h0) ||
                cycle_done !== (r % 16 == 15) || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL single r=%0d: evt=%h done=%b busy=%b", r, event_out, cycle_done, busy);
            end
            step();
        end
        do_stop();
    endtask

    task automatic test_three_entries();
        logic [NE-1:0] ev;
        int ix;
        write_entry(0, M0, 4);
        write_entry(1, M1, 10);
        write_entry(2, M2, 0);
        do_start(3);
        for (int r = 0; r < 30; r++) begin
            ev = (r % 15 == 0) ? M0 : (r % 15 == 4) ? M1 : (r % 15 == 14) ? M2 : 64'h0;
            ix = (r % 15 < 4) ? 0 : (r % 15 < 14) ? 1 : 2;
            vectors++;
            if (event_out !== ev || entry_idx !== ix[IW-1:0] || cycle_done !== (r % 15 == 14)) begin
                miscompares++;
                $display("FAIL three r=%0d: evt=%h idx=%0d done=%b required evt=%h idx=%0d",
                         r, event_out, entry_idx, cycle_done, ev, ix);
            end
            step();
        end
        do_stop();
    endtask

    task automatic test_stop_at_activation();
        do_start(3);
        for (int r = 0; r < 3; r++) step();
        do_stop();   // this edge would have activated entry 1
        for (int r = 0; r < 4; r++) begin
            vectors++;
            if (event_out !== '0 || busy !== 1'b0 || entry_idx !== '0) begin
                miscompares++;
                $display("FAIL stop_act r=%0d: evt=%h busy=%b idx=%0d required 0",
                         r, event_out, busy, entry_idx);
            end
            step();
        end
        do_start(3);
        vectors++;
        if (event_out !== M0 || busy !== 1'b1 || entry_idx !== '0) begin
            miscompares++;
            $display("FAIL restart: evt=%h busy=%b idx=%0d required %h 1 0", event_out, busy, entry_idx, M0);
        end
        do_stop();
    endtask

    task automatic test_cfg_write_run();
        logic [NE-1:0] nm1;
        logic [NE-1:0] nm0;
        nm1 = 64'h0123_4567_89ab_cdef;
        nm0 = 64'h00f0_0000_0000_0f00;
        do_start(3);
        step();                       // rel 1, entry 0 active
        write_entry(1, nm1, 10);      // rel 2
        step();
        step();                       // rel 4
        vectors++;
        if (event_out !== nm1 || entry_idx !== 4'd1) begin
            miscompares++;
            $display("FAIL cfg_new_mask: evt=%h idx=%0d required %h 1", event_out, entry_idx, nm1);
        end
        for (int r = 4; r < 14; r++) step();
        write_entry(0, nm0, 4);       // written on the edge that re-activates entry 0
        vectors++;
        if (event_out !== M0) begin
            miscompares++;
            $display("FAIL cfg_same_edge: evt=%h required old %h", event_out, M0);
        end
        for (int r = 15; r < 30; r++) step();
        vectors++;
        if (event_out !== nm0) begin
            miscompares++;
            $display("FAIL cfg_next_pass: evt=%h required %h", event_out, nm0);
        end
        do_stop();
    endtask

    task automatic test_start_err();
        int bad [2];
        bad[0] = 0;
        bad[1] = 17;
        for (int b = 0; b < 2; b++) begin
            do_start(bad[b]);
            vectors++;
            if (start_err !== 1'b1 || busy !== 1'b0 || event_out !== '0) begin
                miscompares++;
                $display("FAIL start_err n=%0d: err=%b busy=%b evt=%h", bad[b], start_err, busy, event_out);
            end
            step();
            vectors++;
            if (start_err !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL start_err_clr n=%0d: err=%b busy=%b required 0 0", bad[b], start_err, busy);
            end
        end
    endtask

    task automatic test_start_stop_idle();
        cfg_num_entries = 5'd3;
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        for (int r = 0; r < 3; r++) begin
            vectors++;
            if (busy !== 1'b0 || event_out !== '0 || start_err !== 1'b0) begin
                miscompares++;
                $display("FAIL start_stop r=%0d: busy=%b evt=%h err=%b required 0", r, busy, event_out, start_err);
            end
            step();
        end
    endtask

    task automatic test_rst_mid();
        do_start(3);
        for (int r = 0; r < 6; r++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if (event_out !== '0 || busy !== 1'b0 || entry_idx !== '0 ||
            cycle_done !== 1'b0 || start_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid: evt=%h busy=%b idx=%0d done=%b err=%b required 0",
                     event_out, busy, entry_idx, cycle_done, start_err);
        end
        for (int r = 0; r < 20; r++) begin
            step();
            vectors++;
            if (event_out !== '0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_quiet r=%0d: evt=%h busy=%b required 0", r, event_out, busy);
            end
        end
    endtask

    task automatic test_random();
        int ix;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom % 300 == 0);
            start = ($urandom % 15 == 0);
            stop = ($urandom % 70 == 0);
            cfg_we = ($urandom % 5 == 0);
            cfg_addr = IW'($urandom);
            cfg_mask = ($urandom % 6 == 0) ? 64'h0 : {$urandom, $urandom};
            cfg_duration = DW'($urandom_range(0, 6));
            cfg_num_entries = ($urandom % 8 == 0) ? 5'($urandom_range(0, 31))
                                                  : 5'($urandom_range(1, 16));
            step();
            ix = m_cur;
            vectors++;
            if (event_out !== x_evt || busy !== m_run || entry_idx !== ix[IW-1:0] ||
                cycle_done !== x_done || start_err !== x_err) begin
                miscompares++;
                $display("FAIL random c=%0d: evt=%h busy=%b idx=%0d done=%b err=%b required %h %b %0d %b %b",
                         c, event_out, busy, entry_idx, cycle_done, start_err,
                         x_evt, m_run, ix, x_done, x_err);
            end
        end
        rst = 1'b0;
        start = 1'b0;
        cfg_we = 1'b0;
        do_stop();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_entry();
        test_three_entries();
        test_stop_at_activation();
        test_cfg_write_run();
        test_start_err();
        test_start_stop_idle();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
